// File: rtl/clk_sw_pkg.sv
// Shared types and constants for the clock-switch request sequencer.
// Used by clk_switch_ctrl in both builds (CLK_SW_ACK_EN defined or not).
package clk_sw_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_ACK = 2'd2
  } sw_state_e;

  localparam logic SEL_CLK1 = 1'b1;
  localparam logic SEL_CLK2 = 1'b0;

  localparam int DEF_SETTLE_CYCLES  = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ff_q <= 2'b00;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Request-side sequencer for the glitch-free clock switch: drives sel_clk1, waits out the settle time,
// then reports done. Define CLK_SW_ACK_EN to add synchronised ACK confirmation with a sticky timeout err.
module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int   SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int   CNT_W          = 8,
  parameter logic DEFAULT_SEL    = SEL_CLK1
`ifdef CLK_SW_ACK_EN
  ,
  parameter int   TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic clk,
  input  logic rstn,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel_clk1,
  output logic cur_sel,
  output logic busy,
  output logic done,
  output logic err
`ifdef CLK_SW_ACK_EN
  ,
  input  logic ack_clk1,
  input  logic ack_clk2
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  sw_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             cur_q, cur_d;
  logic             done_q, done_d;

`ifdef CLK_SW_ACK_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic ack1_s, ack2_s, ack_ok;
  logic err_q, err_d;

  sync_2ff u_sync_ack1 (.clk(clk), .rstn(rstn), .d_i(ack_clk1), .q_o(ack1_s));
  sync_2ff u_sync_ack2 (.clk(clk), .rstn(rstn), .d_i(ack_clk2), .q_o(ack2_s));

  // The switch has settled once only the target gate is enabled.
  assign ack_ok = (sel_q == SEL_CLK1) ? (ack1_s & ~ack2_s) : (ack2_s & ~ack1_s);
`endif

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
`ifdef CLK_SW_ACK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_sel == cur_q) begin
            done_d = 1'b1;
          end else begin
            sel_d   = req_sel;
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
`ifdef CLK_SW_ACK_EN
            err_d   = 1'b0;
`endif
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
`ifdef CLK_SW_ACK_EN
          cnt_d   = TIMEOUT_LOAD;
          state_d = WAIT_ACK;
`else
          cur_d   = sel_q;
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end
      end
`ifdef CLK_SW_ACK_EN
      WAIT_ACK: begin
        if (ack_ok || cnt_q == '0) begin
          cur_d   = sel_q;
          done_d  = 1'b1;
          state_d = IDLE;
          if (!ack_ok) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= DEFAULT_SEL;
      cur_q   <= DEFAULT_SEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
    end
  end

`ifdef CLK_SW_ACK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign sel_clk1  = sel_q;
  assign cur_sel   = cur_q;
  assign done      = done_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: timeline reference model, per-cycle compare, directed and random stimulus.
// Also covers the CLK_SW_ACK_EN build when that macro is defined.
module tb_clk_switch_ctrl;

  localparam int S  = 16;
  localparam int CW = 8;
`ifdef CLK_SW_ACK_EN
  localparam int TO = 64;
  localparam int EXP_BUSY = S + 1;
`else
  localparam int EXP_BUSY = S;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b1;
  logic req_ready, sel_clk1, cur_sel, busy, done, err;
`ifdef CLK_SW_ACK_EN
  logic ack_clk1 = 1'b1;
  logic ack_clk2 = 1'b0;
  typedef enum {ACK_FOLLOW, ACK_RANDOM, ACK_MANUAL} ack_mode_e;
  ack_mode_e ack_mode = ACK_FOLLOW;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_switch_ctrl #(
    .SETTLE_CYCLES(S),
    .CNT_W(CW),
    .DEFAULT_SEL(1'b1)
`ifdef CLK_SW_ACK_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_sel(req_sel),
    .req_ready(req_ready),
    .sel_clk1(sel_clk1),
    .cur_sel(cur_sel),
    .busy(busy),
    .done(done),
    .err(err)
`ifdef CLK_SW_ACK_EN
    , .ack_clk1(ack_clk1)
    , .ack_clk2(ack_clk2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a timeline of edges since reset. A switching request accepted at
  // edge T0 completes at edge T0+S (or, with ACK, the first edge after that whose
  // two-edge-old ACK sample confirms the target, else T0+S+TO with err).
  int   n = 0;
  bit   active = 1'b0;
  int   settle_end = 0;
  logic m_sel = 1'b1;
  logic m_cur = 1'b1;
  logic m_done = 1'b0;
  logic m_err = 1'b0;
`ifdef CLK_SW_ACK_EN
  bit   h1[$];
  bit   h2[$];

  function automatic bit ack_confirms(bit a1, bit a2, logic target);
    return target ? (a1 && !a2) : (a2 && !a1);
  endfunction
`endif

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        n = 0; active = 1'b0; m_sel = 1'b1; m_cur = 1'b1; m_done = 1'b0; m_err = 1'b0;
`ifdef CLK_SW_ACK_EN
        h1.delete(); h2.delete();
`endif
      end else begin
        n++;
`ifdef CLK_SW_ACK_EN
        h1.push_back(ack_clk1);
        h2.push_back(ack_clk2);
`endif
        m_done = 1'b0;
        if (!active) begin
          if (req_valid) begin
            if (req_sel == m_cur) begin
              m_done = 1'b1;
            end else begin
              active = 1'b1; m_sel = req_sel; settle_end = n + S; m_err = 1'b0;
            end
          end
        end else begin
`ifdef CLK_SW_ACK_EN
          if (n > settle_end) begin
            if (ack_confirms(h1[n-3], h2[n-3], m_sel)) begin
              active = 1'b0; m_cur = m_sel; m_done = 1'b1;
            end else if (n == settle_end + TO) begin
              active = 1'b0; m_cur = m_sel; m_done = 1'b1; m_err = 1'b1;
            end
          end
`else
          if (n == settle_end) begin
            active = 1'b0; m_cur = m_sel; m_done = 1'b1;
          end
`endif
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("req_ready", req_ready, !active);
      check("busy", busy, active);
      check("sel_clk1", sel_clk1, m_sel);
      check("cur_sel", cur_sel, m_cur);
      check("done", done, m_done);
      check("err", err, m_err);
    end
  end

`ifdef CLK_SW_ACK_EN
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        ACK_FOLLOW: begin ack_clk1 = sel_clk1; ack_clk2 = !sel_clk1; end
        ACK_RANDOM: begin
          if ($urandom_range(0, 15) == 0) begin
            ack_clk1 = sel_clk1; ack_clk2 = !sel_clk1;
          end else begin
            ack_clk1 = $urandom_range(0, 1); ack_clk2 = ack_clk1;
          end
        end
        default: ;
      endcase
    end
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      if (req_ready && !busy) break;
      tick();
    end
    check({name, "_idle"}, req_ready, 1'b1);
  endtask

  task automatic count_busy(output int cyc);
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      cyc++;
      tick();
    end
  endtask

  int cyc;

  initial begin
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check("rst_sel", sel_clk1, 1'b1);
    check("rst_cur", cur_sel, 1'b1);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);

    // Same-selection request is a no-op with a done pulse.
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    check("noop_done", done, 1'b1);
    check("noop_sel", sel_clk1, 1'b1);
    check("noop_busy", busy, 1'b0);
    tick();
    check("noop_done_clr", done, 1'b0);

    // clk1 -> clk2 switch.
    req_valid = 1'b1; req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    check("sw_sel", sel_clk1, 1'b0);
    count_busy(cyc);
    check("sw_busy_cycles", cyc, EXP_BUSY);
    check("sw_done", done, 1'b1);
    check("sw_cur", cur_sel, 1'b0);
    check("sw_ready", req_ready, 1'b1);
    tick();
    check("sw_done_clr", done, 1'b0);

    // Held request with wiggling req_sel while busy; next request taken in the done cycle.
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    check("hold_sel_accept", sel_clk1, 1'b1);
    for (int i = 0; i < 200 && busy; i++) begin
      req_sel = ~req_sel;
      check("hold_sel_stable", sel_clk1, 1'b1);
      tick();
    end
    check("hold_done", done, 1'b1);
    check("hold_ready", req_ready, 1'b1);
    req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    check("b2b_sel", sel_clk1, 1'b0);
    check("b2b_busy", busy, 1'b1);
    wait_idle("b2b");
    check("b2b_cur", cur_sel, 1'b0);

    // Reset five cycles into a clk1 -> clk2 sequence.
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_idle("pre_rst");
    check("pre_rst_cur", cur_sel, 1'b1);
    req_valid = 1'b1; req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    check("rst_mid_sel", sel_clk1, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    check("rst_post_done", done, 1'b0);
    req_valid = 1'b1; req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    wait_idle("post_rst");
    check("post_rst_done", done, 1'b1);
    check("post_rst_cur", cur_sel, 1'b0);

    // Random traffic with occasional resets.
`ifdef CLK_SW_ACK_EN
    ack_mode = ACK_RANDOM;
`endif
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_sel   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
      end
      tick();
    end
    req_valid = 1'b0;
    wait_idle("rand_end");

`ifdef CLK_SW_ACK_EN
    ack_mode = ACK_MANUAL;
    ack_clk1 = 1'b1; ack_clk2 = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    // ACK for clk2 arrives ten cycles after the settle period.
    req_valid = 1'b1; req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (S + 10) tick();
    ack_clk1 = 1'b0; ack_clk2 = 1'b1;
    wait_idle("ack_ok");
    check("ack_ok_done", done, 1'b1);
    check("ack_ok_err", err, 1'b0);
    check("ack_ok_cur", cur_sel, 1'b0);
    tick();
    // clk1 ACK never arrives: timeout after S + TO busy cycles.
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    count_busy(cyc);
    check("to_busy_cycles", cyc, S + TO);
    check("to_done", done, 1'b1);
    check("to_err", err, 1'b1);
    check("to_cur", cur_sel, 1'b1);
    tick();
    check("to_err_sticky", err, 1'b1);
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    check("to_noop_err", err, 1'b1);
    req_valid = 1'b1; req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    check("to_clear_err", err, 1'b0);
    wait_idle("to_clear");
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
Request-side sequencer for the glitch-free clock switch. It runs on a free-running always-on reference clock and accepts switch requests over a valid/ready handshake. It drives the switch's select input (1 = clk1, 0 = clk2), holds off further requests until the switch has settled, and then reports completion. It is the initiator for the switch: it generates sel_clk1, which the switch consumes.

Parameters:
SETTLE_CYCLES, 16, clk cycles to wait after sel_clk1 changes; legal range 1..2**CNT_W; set ≥ 6 periods of the slowest switched clock, in clk cycles
CNT_W, 8, settle/timeout counter width
DEFAULT_SEL, 1, value of sel_clk1 and cur_sel at reset; must match the switch's reset selection (clk1)
TIMEOUT_CYCLES, 64, ACK wait limit in clk cycles; used only with CLK_SW_ACK_EN; legal range 1..2**CNT_W

Ports:
clk  input  1  always-on reference clock, rising edge
rstn  input  1  asynchronous active-low reset
req_valid  input  1  switch request valid
req_sel  input  1  requested clock: 1 = clk1, 0 = clk2
req_ready  output  1  request accepted when req_valid & req_ready at a clk edge
sel_clk1  output  1  registered select to the clock switch
cur_sel  output  1  last completed selection
busy  output  1  switch sequence in progress
done  output  1  one-cycle pulse: request completed
err  output  1  sticky ACK timeout flag (only with CLK_SW_ACK_EN, else tied 0)
ack_clk1  input  1  asynchronous clk1 gate-enable status from the switch (only with CLK_SW_ACK_EN)
ack_clk2  input  1  asynchronous clk2 gate-enable status from the switch (only with CLK_SW_ACK_EN)

Behaviour:
- Single clock: clk. Reset: asynchronous, active-low (rstn).
- Reset values: sel_clk1 = cur_sel = DEFAULT_SEL, req_ready = 1, busy = 0, done = 0, err = 0, state = IDLE, counter = 0.
- All outputs are registered. req_ready = (state == IDLE). busy = !req_ready.
- States: IDLE, SETTLE, WAIT_ACK. WAIT_ACK exists only with CLK_SW_ACK_EN.
- IDLE, request accepted with req_sel == cur_sel: no-op. sel_clk1 is unchanged, state stays IDLE, done pulses on the next cycle, req_ready stays 1.
- IDLE, request accepted with req_sel != cur_sel, at edge T0:
  - sel_clk1 <= req_sel
  - counter <= SETTLE_CYCLES-1
  - state <= SETTLE
  - err <= 0
- SETTLE, each edge:
  - counter != 0: decrement the counter.
  - counter == 0: cur_sel <= sel_clk1, done <= 1, state <= IDLE.
  - done is therefore high in the cycle after edge T0+SETTLE_CYCLES; the total busy time is SETTLE_CYCLES cycles.
- sel_clk1 changes only on request acceptance and on reset. It never toggles during SETTLE or WAIT_ACK.
- Requests presented while busy are not accepted. The requester holds req_valid and req_sel until req_ready. req_sel changing while not accepted has no effect.
- Back-to-back: a request can be accepted in the same cycle done is high, because state is already IDLE.
- done is a one-cycle pulse and is 0 in every other cycle.
- Reset mid-sequence: returns to the reset values immediately (sel_clk1 = DEFAULT_SEL). The sequence is abandoned and no done pulse is generated.
- Counter arithmetic is unsigned CNT_W bits. The counter never wraps because decrementing stops at 0.

Optional Feature:
Macro: CLK_SW_ACK_EN.
- Defined:
  - ack_clk1 and ack_clk2 ports exist. Each passes through its own 2-flop synchroniser.
  - SETTLE counter==0 goes to WAIT_ACK (not IDLE), loading counter <= TIMEOUT_CYCLES-1.
  - In WAIT_ACK, when the synchronised target ack is 1 and the other ack is 0: cur_sel <= sel_clk1, done <= 1, state <= IDLE.
  - If the counter reaches 0 first: err <= 1, done <= 1, cur_sel <= sel_clk1, state <= IDLE.
  - err is sticky until the next accepted switching request or reset.
- Undefined: no ack ports, no WAIT_ACK state, err tied 0, and the timing is pure settle-count as above.

Decomposition:
- Shared package clk_sw_pkg:
  - state enum: IDLE, SETTLE, WAIT_ACK
  - constants SEL_CLK1 = 1'b1, SEL_CLK2 = 1'b0
  - default SETTLE_CYCLES and TIMEOUT_CYCLES values
- Sub-module sync_2ff: 2-flop synchroniser with reset value 0, instantiated for each ack under CLK_SW_ACK_EN.

Test Plan:
1. Reset, SETTLE_CYCLES=16 -> sel_clk1=1, cur_sel=1, req_ready=1, busy=0, done=0 after rstn release.
2. Request req_sel=0 accepted at edge T0 -> sel_clk1=0 after T0; busy=1 for exactly 16 cycles; done high only in the cycle after T0+16; then cur_sel=0, req_ready=1.
3. Request req_sel=1 while cur_sel=1 -> sel_clk1 stays 1, busy stays 0, done pulses the next cycle.
4. req_valid held high with alternating req_sel during SETTLE -> no acceptance until IDLE; sel_clk1 stable; the pending request is accepted in the done cycle.
5. rstn asserted 5 cycles into a clk1->clk2 sequence -> sel_clk1=1 immediately, no done pulse; a new request after release completes normally.
6. CLK_SW_ACK_EN, TIMEOUT_CYCLES=64:
   - ack_clk2 rises 10 cycles after settle -> done with err=0.
   - ack_clk2 held 0 -> done and err=1 exactly 64 cycles after settle end; err clears on the next accepted switching request.
